// File: rtl/cam_switch_n.sv
`default_nettype none
// ============================================================================
// Module  : cam_switch_n
// Purpose : Frame-synchronous N-channel video source selector with loss fill.
// Revision: 1.0
// ============================================================================
module cam_switch_n #(
    parameter int          H_ACT        = 1280,
    parameter int          V_ACT        = 720,
    parameter int          NUM_CH       = 4,
    parameter int          DELAY        = 2,
    parameter int          INIT_CH      = 0,
    parameter int          CYCLE_FRAMES = 60,
    parameter logic [23:0] FILL_RGB     = 24'h0000FF,
    localparam int         c_XW         = $clog2(H_ACT),
    localparam int         c_YW         = $clog2(V_ACT),
    localparam int         c_CW         = $clog2(NUM_CH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 m_hsync,
    input  logic                 m_vsync,
    input  logic                 m_de,
    input  logic [c_XW-1:0]      m_x,
    input  logic [c_YW-1:0]      m_y,
    input  logic [NUM_CH-1:0]    ch_de,
    input  logic [24*NUM_CH-1:0] ch_rgb,
    input  logic                 sel_valid,
    input  logic [c_CW-1:0]      sel_idx,
    input  logic                 next_key,
    input  logic                 auto_en,
    output logic                 o_hsync,
    output logic                 o_vsync,
    output logic                 o_de,
    output logic [c_XW-1:0]      o_x,
    output logic [c_YW-1:0]      o_y,
    output logic [23:0]          o_rgb,
    output logic [c_CW-1:0]      cur_idx,
    output logic                 pending,
    output logic [NUM_CH-1:0]    ch_lost
);

    localparam int              c_FW      = (CYCLE_FRAMES > 1) ? $clog2(CYCLE_FRAMES) : 1;
    localparam logic [c_FW-1:0] c_CF_LAST = c_FW'(CYCLE_FRAMES - 1);
    localparam logic [c_CW-1:0] c_INIT    = c_CW'(INIT_CH);
    localparam logic [c_CW-1:0] c_LAST    = c_CW'(NUM_CH - 1);
    localparam logic [c_CW:0]   c_NCH     = (c_CW + 1)'(NUM_CH);

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_PEND = 1'b1;

    logic                    r_vs_d;
    logic                    w_fb;
    logic [0:0]              r_state;
    logic [c_CW-1:0]         r_cur;
    logic [c_CW-1:0]         r_target;
    logic [c_FW-1:0]         r_cnt;
    logic [NUM_CH-1:0]       r_seen;
    logic [NUM_CH-1:0]       r_lost;
    logic                    w_sel_ok;
    logic [c_CW-1:0]         w_base;
    logic [c_CW-1:0]         w_key_tgt;
    logic [c_CW-1:0]         w_auto_nxt;
    logic [23:0]             w_ch_rgb [NUM_CH];
    logic [23:0]             w_pix;

    logic [DELAY-1:0]            r_hs;
    logic [DELAY-1:0]            r_vs;
    logic [DELAY-1:0]            r_de;
    logic [DELAY-1:0][c_XW-1:0]  r_x;
    logic [DELAY-1:0][c_YW-1:0]  r_y;
    logic [DELAY-1:0][23:0]      r_rgb;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_unpack
        assign w_ch_rgb[i] = ch_rgb[24*i +: 24];
    end

    assign w_fb      = m_vsync & ~r_vs_d;
    assign w_sel_ok  = sel_valid && ({1'b0, sel_idx} < c_NCH);
    // Key steps chain off a still-pending target so repeated presses accumulate.
    assign w_base    = (r_state == c_PEND) ? r_target : r_cur;
    assign w_key_tgt = (w_base == c_LAST) ? '0 : w_base + 1'b1;

    // First non-lost channel after r_cur, wrapping; holds r_cur if none.
    always_comb begin
        int   j;
        logic found;
        j          = 0;
        found      = 1'b0;
        w_auto_nxt = r_cur;
        for (int k = 1; k < NUM_CH; k++) begin
            j = int'(r_cur) + k;
            if (j >= NUM_CH) j = j - NUM_CH;
            if (!found && !r_lost[j[c_CW-1:0]]) begin
                w_auto_nxt = j[c_CW-1:0];
                found      = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vs_d   <= 1'b0;
            r_state  <= c_IDLE;
            r_cur    <= c_INIT;
            r_target <= c_INIT;
            r_cnt    <= '0;
            r_seen   <= '0;
            r_lost   <= '0;
        end else begin
            r_vs_d <= m_vsync;
            if (w_fb) begin
                r_lost <= ~r_seen;
                r_seen <= '0;
            end else begin
                r_seen <= r_seen | ch_de;
            end

            if (auto_en) begin
                r_state <= c_IDLE;
                if (w_fb) begin
                    if (r_cnt == c_CF_LAST) begin
                        r_cnt <= '0;
                        r_cur <= w_auto_nxt;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            end else begin
                r_cnt <= '0;
                if (w_fb && (r_state == c_PEND)) begin
                    r_cur   <= r_target;
                    r_state <= c_IDLE;
                end
                // A request in the fb cycle re-arms PEND for the following frame.
                if (w_sel_ok) begin
                    r_target <= sel_idx;
                    r_state  <= c_PEND;
                end else if (next_key) begin
                    r_target <= w_key_tgt;
                    r_state  <= c_PEND;
                end
            end
        end
    end

    assign w_pix = !m_de             ? 24'h0    :
                   r_lost[r_cur]     ? FILL_RGB :
                                       w_ch_rgb[r_cur];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hs  <= '0;
            r_vs  <= '0;
            r_de  <= '0;
            r_x   <= '0;
            r_y   <= '0;
            r_rgb <= '0;
        end else begin
            r_hs[0]  <= m_hsync;
            r_vs[0]  <= m_vsync;
            r_de[0]  <= m_de;
            r_x[0]   <= m_x;
            r_y[0]   <= m_y;
            r_rgb[0] <= w_pix;
            for (int i = 1; i < DELAY; i++) begin
                r_hs[i]  <= r_hs[i-1];
                r_vs[i]  <= r_vs[i-1];
                r_de[i]  <= r_de[i-1];
                r_x[i]   <= r_x[i-1];
                r_y[i]   <= r_y[i-1];
                r_rgb[i] <= r_rgb[i-1];
            end
        end
    end

    assign o_hsync = r_hs[DELAY-1];
    assign o_vsync = r_vs[DELAY-1];
    assign o_de    = r_de[DELAY-1];
    assign o_x     = r_x[DELAY-1];
    assign o_y     = r_y[DELAY-1];
    assign o_rgb   = r_rgb[DELAY-1];
    assign cur_idx = r_cur;
    assign pending = (r_state == c_PEND);
    assign ch_lost = r_lost;

endmodule
`default_nettype wire

// File: tb/tb_cam_switch_n.sv
`default_nettype none
// ============================================================================
// Module  : tb_cam_switch_n
// Purpose : Self-checking bench for cam_switch_n (small frame geometry).
// Revision: 1.0
// ============================================================================
module tb_cam_switch_n;

    localparam int          H_ACT        = 8;
    localparam int          V_ACT        = 4;
    localparam int          NUM_CH       = 4;
    localparam int          DELAY        = 2;
    localparam int          INIT_CH      = 0;
    localparam int          CYCLE_FRAMES = 2;
    localparam logic [23:0] FILL_RGB     = 24'h0000FF;
    localparam int          XW           = $clog2(H_ACT);
    localparam int          YW           = $clog2(V_ACT);
    localparam int          CW           = $clog2(NUM_CH);

    localparam int K_NONE = 0;
    localparam int K_SEL  = 1;
    localparam int K_KEY  = 2;
    localparam int K_BOTH = 3;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 m_hsync, m_vsync, m_de;
    logic [XW-1:0]        m_x;
    logic [YW-1:0]        m_y;
    logic [NUM_CH-1:0]    ch_de;
    logic [24*NUM_CH-1:0] ch_rgb;
    logic                 sel_valid;
    logic [CW-1:0]        sel_idx;
    logic                 next_key;
    logic                 auto_en;
    logic                 o_hsync, o_vsync, o_de;
    logic [XW-1:0]        o_x;
    logic [YW-1:0]        o_y;
    logic [23:0]          o_rgb;
    logic [CW-1:0]        cur_idx;
    logic                 pending;
    logic [NUM_CH-1:0]    ch_lost;

    always #5 clk = ~clk;

    cam_switch_n #(
        .H_ACT(H_ACT), .V_ACT(V_ACT), .NUM_CH(NUM_CH), .DELAY(DELAY),
        .INIT_CH(INIT_CH), .CYCLE_FRAMES(CYCLE_FRAMES), .FILL_RGB(FILL_RGB)
    ) dut (
        .clk(clk), .rst(rst),
        .m_hsync(m_hsync), .m_vsync(m_vsync), .m_de(m_de), .m_x(m_x), .m_y(m_y),
        .ch_de(ch_de), .ch_rgb(ch_rgb),
        .sel_valid(sel_valid), .sel_idx(sel_idx), .next_key(next_key), .auto_en(auto_en),
        .o_hsync(o_hsync), .o_vsync(o_vsync), .o_de(o_de), .o_x(o_x), .o_y(o_y),
        .o_rgb(o_rgb), .cur_idx(cur_idx), .pending(pending), .ch_lost(ch_lost)
    );

    typedef struct packed {
        logic          hs;
        logic          vs;
        logic          de;
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic [23:0]   rgb;
    } pix_t;

    typedef struct {
        logic [3:0] mask;
        logic       aut;
        int         kind;
        logic [1:0] idx;
        int         n;
        logic       at_fb;
        logic [1:0] e_cur;
        logic [3:0] e_lost;
        logic       e_pend;
    } row_t;

    pix_t        sb_q[$];
    row_t        rows[$];
    logic [23:0] base_rgb [NUM_CH] = '{24'h0A0B0C, 24'h445566, 24'h112233, 24'h778899};
    int          errors = 0;
    int          checks = 0;

    // Reference model state
    logic [1:0]  md_cur, md_tgt;
    logic        md_pend, md_vsp;
    int          md_cnt;
    logic [3:0]  md_seen, md_lost;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        md_cur  = 2'(INIT_CH);
        md_tgt  = 2'(INIT_CH);
        md_pend = 1'b0;
        md_vsp  = 1'b0;
        md_cnt  = 0;
        md_seen = '0;
        md_lost = '0;
    endtask

    task automatic tick();
        pix_t       e;
        logic       fb;
        logic [1:0] base;
        logic [1:0] nxt;
        fb    = m_vsync && !md_vsp;
        e.hs  = m_hsync;
        e.vs  = m_vsync;
        e.de  = m_de;
        e.x   = m_x;
        e.y   = m_y;
        e.rgb = !m_de ? 24'h0 : (md_lost[md_cur] ? FILL_RGB : ch_rgb[24*int'(md_cur) +: 24]);
        sb_q.push_back(e);
        @(posedge clk);
        if (auto_en) begin
            md_pend = 1'b0;
            if (fb) begin
                if (md_cnt == CYCLE_FRAMES - 1) begin
                    md_cnt = 0;
                    nxt    = md_cur;
                    for (int k = NUM_CH - 1; k >= 1; k--) begin
                        int c2;
                        c2 = (int'(md_cur) + k) % NUM_CH;
                        if (!md_lost[c2]) nxt = 2'(c2);
                    end
                    md_cur = nxt;
                end else begin
                    md_cnt++;
                end
            end
        end else begin
            md_cnt = 0;
            base   = md_pend ? md_tgt : md_cur;
            if (fb && md_pend) begin
                md_cur  = md_tgt;
                md_pend = 1'b0;
            end
            if (sel_valid && int'(sel_idx) < NUM_CH) begin
                md_tgt  = sel_idx;
                md_pend = 1'b1;
            end else if (next_key) begin
                md_tgt  = 2'((int'(base) + 1) % NUM_CH);
                md_pend = 1'b1;
            end
        end
        if (fb) begin
            md_lost = ~md_seen;
            md_seen = '0;
        end else begin
            md_seen = md_seen | ch_de;
        end
        md_vsp = m_vsync;
        #1;
        if (sb_q.size() >= DELAY) begin
            e = sb_q.pop_front();
            check("pix", 64'({o_hsync, o_vsync, o_de, o_x, o_y, o_rgb}), 64'(e));
        end else begin
            check("pix_fill", 64'({o_hsync, o_vsync, o_de, o_x, o_y, o_rgb}), 64'(0));
        end
        check("state", 64'({cur_idx, pending, ch_lost}), 64'({md_cur, md_pend, md_lost}));
    endtask

    task automatic drive_req(input int kind, input logic [1:0] idx);
        sel_valid = (kind == K_SEL) || (kind == K_BOTH);
        next_key  = (kind == K_KEY) || (kind == K_BOTH);
        sel_idx   = idx;
    endtask

    task automatic clear_req();
        sel_valid = 1'b0;
        next_key  = 1'b0;
    endtask

    task automatic set_active(input int x, input int y, input logic [3:0] mask);
        m_hsync = 1'b0;
        m_vsync = 1'b0;
        m_de    = 1'b1;
        m_x     = XW'(x);
        m_y     = YW'(y);
        ch_de   = mask;
        for (int i = 0; i < NUM_CH; i++)
            ch_rgb[24*i +: 24] = base_rgb[i] ^ {8'h00, 8'(y), 8'(x)};
    endtask

    task automatic set_blank(input logic hs, input logic vs);
        m_hsync = hs;
        m_vsync = vs;
        m_de    = 1'b0;
        ch_de   = '0;
    endtask

    task automatic line_cycle(input int x, input int y, input logic [3:0] mask);
        if (x < H_ACT) set_active(x, y, mask);
        else           set_blank(x == H_ACT, 1'b0);
    endtask

    task automatic run_frame(input logic [3:0] mask, input logic aut, input int kind,
                             input logic [1:0] idx, input int n, input logic at_fb);
        int pulses;
        pulses  = 0;
        auto_en = aut;
        for (int c = 0; c < 4; c++) begin
            set_blank(1'b0, c < 2);
            if (c == 0 && at_fb) drive_req(kind, idx);
            tick();
            clear_req();
        end
        for (int y = 0; y < V_ACT; y++) begin
            for (int x = 0; x < H_ACT + 3; x++) begin
                line_cycle(x, y, mask);
                if (!at_fb && y == 1 && x >= 2 && x % 2 == 0 && pulses < n) begin
                    drive_req(kind, idx);
                    pulses++;
                end
                tick();
                clear_req();
            end
        end
    endtask

    task automatic add_row(input logic [3:0] mask, input logic aut, input int kind,
                           input logic [1:0] idx, input int n, input logic at_fb,
                           input logic [1:0] e_cur, input logic [3:0] e_lost, input logic e_pend);
        row_t r;
        r.mask = mask; r.aut = aut; r.kind = kind; r.idx = idx; r.n = n; r.at_fb = at_fb;
        r.e_cur = e_cur; r.e_lost = e_lost; r.e_pend = e_pend;
        rows.push_back(r);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // mask, auto, kind, idx, pulses, at_fb  ->  cur, lost, pending
        add_row(4'hF, 1'b0, K_NONE, 2'd0, 0, 1'b0, 2'd0, 4'hF, 1'b0); // nothing seen since reset
        add_row(4'hF, 1'b0, K_SEL,  2'd2, 1, 1'b0, 2'd0, 4'h0, 1'b1);
        add_row(4'hF, 1'b0, K_NONE, 2'd0, 0, 1'b0, 2'd2, 4'h0, 1'b0);
        add_row(4'hF, 1'b0, K_KEY,  2'd0, 1, 1'b0, 2'd2, 4'h0, 1'b1);
        add_row(4'h7, 1'b0, K_NONE, 2'd0, 0, 1'b0, 2'd3, 4'h0, 1'b0); // ch3 silent
        add_row(4'hF, 1'b0, K_NONE, 2'd0, 0, 1'b0, 2'd3, 4'h8, 1'b0); // ch3 lost, fill shown
        add_row(4'hF, 1'b0, K_NONE, 2'd0, 0, 1'b0, 2'd3, 4'h0, 1'b0);
        add_row(4'hF, 1'b0, K_BOTH, 2'd1, 1, 1'b0, 2'd3, 4'h0, 1'b1); // select beats key
        add_row(4'hF, 1'b0, K_NONE, 2'd0, 0, 1'b0, 2'd1, 4'h0, 1'b0);
        add_row(4'hF, 1'b0, K_KEY,  2'd0, 3, 1'b0, 2'd1, 4'h0, 1'b1); // 1->2->3->0
        add_row(4'hF, 1'b0, K_NONE, 2'd0, 0, 1'b0, 2'd0, 4'h0, 1'b0);
        add_row(4'hF, 1'b0, K_SEL,  2'd2, 1, 1'b1, 2'd0, 4'h0, 1'b1); // request in fb cycle
        add_row(4'hF, 1'b0, K_NONE, 2'd0, 0, 1'b0, 2'd2, 4'h0, 1'b0);
        add_row(4'hF, 1'b0, K_SEL,  2'd2, 1, 1'b0, 2'd2, 4'h0, 1'b1); // same channel
        add_row(4'hF, 1'b0, K_NONE, 2'd0, 0, 1'b0, 2'd2, 4'h0, 1'b0);
        add_row(4'hF, 1'b0, K_SEL,  2'd1, 1, 1'b0, 2'd2, 4'h0, 1'b1);
        add_row(4'hF, 1'b0, K_KEY,  2'd0, 1, 1'b1, 2'd1, 4'h0, 1'b1); // commit + re-arm
        add_row(4'hF, 1'b0, K_NONE, 2'd0, 0, 1'b0, 2'd2, 4'h0, 1'b0);
        add_row(4'hF, 1'b0, K_SEL,  2'd0, 1, 1'b0, 2'd2, 4'h0, 1'b1);
        add_row(4'hD, 1'b0, K_NONE, 2'd0, 0, 1'b0, 2'd0, 4'h0, 1'b0);
        add_row(4'hD, 1'b1, K_SEL,  2'd3, 1, 1'b0, 2'd0, 4'h2, 1'b0); // auto: select ignored
        add_row(4'hD, 1'b1, K_NONE, 2'd0, 0, 1'b0, 2'd2, 4'h2, 1'b0);
        add_row(4'hD, 1'b1, K_NONE, 2'd0, 0, 1'b0, 2'd2, 4'h2, 1'b0);
        add_row(4'hD, 1'b1, K_NONE, 2'd0, 0, 1'b0, 2'd3, 4'h2, 1'b0);
        add_row(4'hD, 1'b1, K_NONE, 2'd0, 0, 1'b0, 2'd3, 4'h2, 1'b0);
        add_row(4'h1, 1'b1, K_NONE, 2'd0, 0, 1'b0, 2'd0, 4'h2, 1'b0);
        add_row(4'h1, 1'b1, K_NONE, 2'd0, 0, 1'b0, 2'd0, 4'hE, 1'b0);
        add_row(4'h1, 1'b1, K_NONE, 2'd0, 0, 1'b0, 2'd0, 4'hE, 1'b0); // all others lost
        add_row(4'hF, 1'b0, K_KEY,  2'd0, 1, 1'b0, 2'd0, 4'hE, 1'b1);
        add_row(4'hF, 1'b0, K_NONE, 2'd0, 0, 1'b0, 2'd1, 4'h0, 1'b0);
        add_row(4'hF, 1'b0, K_SEL,  2'd3, 1, 1'b0, 2'd1, 4'h0, 1'b1);
        add_row(4'hF, 1'b1, K_NONE, 2'd0, 0, 1'b0, 2'd1, 4'h0, 1'b0); // auto drops request
        add_row(4'hF, 1'b0, K_NONE, 2'd0, 0, 1'b0, 2'd1, 4'h0, 1'b0);

        rst = 1'b1;
        set_blank(1'b0, 1'b0);
        m_x = '0; m_y = '0; ch_rgb = '0;
        sel_idx = '0; auto_en = 1'b0;
        clear_req();
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        check("reset_out", 64'({o_hsync, o_vsync, o_de, o_x, o_y, o_rgb}), 64'(0));
        check("reset_state", 64'({cur_idx, pending, ch_lost}), 64'({2'(INIT_CH), 1'b0, 4'h0}));
        rst = 1'b0;

        for (int r = 0; r < rows.size(); r++) begin
            run_frame(rows[r].mask, rows[r].aut, rows[r].kind, rows[r].idx, rows[r].n, rows[r].at_fb);
            check($sformatf("row%0d", r), 64'({cur_idx, ch_lost, pending}),
                  64'({rows[r].e_cur, rows[r].e_lost, rows[r].e_pend}));
        end

        // Mid-frame asynchronous reset with a pending request and a non-zero channel.
        auto_en = 1'b0;
        for (int c = 0; c < 4; c++) begin
            set_blank(1'b0, c < 2);
            tick();
        end
        for (int x = 0; x < 3; x++) begin
            set_active(x, 0, 4'hF);
            if (x == 1) drive_req(K_KEY, 2'd0);
            tick();
            clear_req();
        end
        check("pre_reset", 64'({o_de, cur_idx, pending}), 64'({1'b1, 2'd1, 1'b1}));
        rst = 1'b1;
        #1;
        check("async_reset_out", 64'({o_hsync, o_vsync, o_de, o_x, o_y, o_rgb}), 64'(0));
        check("async_reset_state", 64'({cur_idx, pending, ch_lost}), 64'({2'(INIT_CH), 1'b0, 4'h0}));
        @(posedge clk); #1;
        check("reset_hold", 64'({o_de, cur_idx, pending}), 64'({1'b0, 2'(INIT_CH), 1'b0}));
        rst = 1'b0;
        model_reset();
        sb_q.delete();
        for (int y = 0; y < V_ACT; y++) begin
            for (int x = (y == 0) ? 3 : 0; x < H_ACT + 3; x++) begin
                line_cycle(x, y, 4'hF);
                tick();
            end
        end
        run_frame(4'hF, 1'b0, K_NONE, 2'd0, 0, 1'b0);
        check("post_reset_frame", 64'({cur_idx, ch_lost, pending}), 64'({2'd0, 4'h0, 1'b0}));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
